ff_accum_processor_set: RTL and testbench
=========================================

Name: ff_accum_processor_set

Overview:
- Feedforward processor set for a junction with a single output lane, for cases where neuron fan-in fi exceeds the z multipliers per cycle.
- Each neuron's z·cpn activation-weight products are accumulated over cpn beats, then bias is added, the sum is saturated, and act/adot are produced under a run-time activation mode.
- Valid/ready handshakes on input and output. Sits between junction memories and the next layer's act/adot memories.

Parameters:
- z, 8, multiplier lanes (products per beat)
- cpn, 2, beats per neuron; neuron fan-in fi = z*cpn; cpn ≥ 1
- width, 16, data width (two's complement fixed point)
- int_bits, 5, integer bits excluding sign
- frac_bits, 10, fractional bits; width = 1+int_bits+frac_bits
- width_acc, width+$clog2(z*cpn)+1, accumulator width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- act_mode  in  1  0 = ReLU, 1 = hard sigmoid; sampled on the first beat of each neuron
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- act_in_package  in  width*z  z unsigned activations
- wt_package  in  width*z  z signed weights
- bias  in  width  signed bias; sampled on the first beat only
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- act_out  out  width  activation
- adot_out  out  width  activation derivative
- beat_cnt  out  $clog2(cpn+1)  current beat index, for debug

Behaviour:
- Reset: asynchronous on reset_n low; all state clears immediately. in_ready=1, out_valid=0, act_out=0, adot_out=0, beat_cnt=0, accumulator=0.
- Product per lane:
  - Full 2*width signed product of {0,act} and wt.
  - Arithmetic shift right by frac_bits; truncation rounds toward −inf.
  - Saturate to width bits: 0x7FFF / 0x8000 for width=16.
- Beat sum: sign-extend the z products to width_acc and add them (adder tree or sequential, designer's choice; cycle timing must hold).
- States:
  - ACCUM: beat_cnt 0..cpn-1.
    - Accepted beat with beat_cnt=0: acc ← bias_ext + beat sum; act_mode latched.
    - Other accepted beats: acc ← acc + beat sum.
    - beat_cnt increments on each accept and wraps to 0 after cpn-1.
    - No accept: acc and beat_cnt hold.
  - Last beat (beat_cnt=cpn-1) accepted: s = saturate(acc + beat sum) to width. act/adot are registered in the following cycle, and out_valid rises 1 cycle after the accept.
- ReLU mode:
  - act = s if s>0, else 0.
  - adot = 1<<frac_bits if s>0, else 0.
- Hard-sigmoid mode:
  - act = clamp((s>>>2) + (1<<(frac_bits-1)), 0, 1<<frac_bits).
  - adot = 1<<(frac_bits-2) if −2.0 < s < 2.0 (strict), else 0.
- Output register: a single entry. It holds its values and out_valid until out_valid & out_ready.
- in_ready = ~out_valid | out_ready | (beat_cnt != cpn-1). Non-last beats always proceed. The last beat stalls only while the output is full and not draining.
- Simultaneous events:
  - Output drain and a new last-beat accept in the same cycle: new result is loaded next cycle; out_valid stays 1.
  - With cpn=1, one neuron per cycle at full throughput.
- Reset mid-neuron discards the partial accumulation; the next accepted beat is beat 0.
- in_valid=0 mid-neuron: idle cycles are allowed; no timeout.

Optional Feature:
- FF_ROUND_EN
- Defined: each product adds bit[frac_bits-1] of the full product before saturation (round half up). The hard-sigmoid s>>>2 adds s[1] (round half up).
- Undefined: truncation as above.
- Both variants are cycle-identical.

Test Plan (width=16, frac_bits=10, z=4, cpn=2):
- ReLU: act 1024 ×8, wt 512 ×8, bias 0, mode 0 → act_out 4096, adot_out 1024, out_valid 1 cycle after the 2nd beat.
- Hard sigmoid, same data with mode 1 → act_out 1024, adot_out 0. Same data with wt 64 ×8 (s=512) → act_out 640, adot_out 256.
- Saturation: act 31744, wt 31744, bias 32767 → every product saturates to 32767; s=32767; ReLU act_out 32767. Negative case: wt −1024, act 1024 → s=−8192; act_out 0, adot_out 0 in both modes.
- Backpressure: out_ready=0 for 5 cycles with two neurons in flight → 2nd neuron's beat 0 accepted, its last beat held (in_ready=0). out_ready=1 → first result drains, second result appears the next cycle, none lost or duplicated.
- Reset mid-neuron: reset_n low after beat 0 → out_valid 0, beat_cnt 0. The next two beats (act 1024, wt 1024, bias 0) → act_out 8192.
- FF_ROUND_EN: act 1, wt 512 (product 0.5 LSB), bias 0, ReLU → per-product 1 with the macro, 0 without; act_out 8 vs 0.

Source files
------------

// File: rtl/ff_accum_processor_set.sv
// Feedforward processor set: accumulates z*cpn activation-weight products per neuron, adds bias,
// saturates, and applies ReLU or hard sigmoid. Define FF_ROUND_EN for round-half-up instead of truncation.
module ff_accum_processor_set #(
    parameter int z         = 8,
    parameter int cpn       = 2,
    parameter int width     = 16,
    parameter int int_bits  = 5,
    parameter int frac_bits = 10,
    parameter int width_acc = width + $clog2(z * cpn) + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      act_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [width*z-1:0]        act_in_package,
    input  logic [width*z-1:0]        wt_package,
    input  logic [width-1:0]          bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width-1:0]          act_out,
    output logic [width-1:0]          adot_out,
    output logic [$clog2(cpn+1)-1:0]  beat_cnt
);

    localparam int bw = $clog2(cpn + 1);
    localparam int pw = 2 * width + 1;
    localparam int hw = width + 2;

    localparam logic [bw-1:0] LAST_BEAT = bw'(cpn - 1);

    localparam logic signed [pw-1:0] P_MAX = pw'((2 ** (width - 1)) - 1);
    localparam logic signed [pw-1:0] P_MIN = -P_MAX - pw'(1);
    localparam logic signed [width_acc-1:0] A_MAX = width_acc'((2 ** (width - 1)) - 1);
    localparam logic signed [width_acc-1:0] A_MIN = -A_MAX - width_acc'(1);
    localparam logic signed [width-1:0] W_MAX = width'((2 ** (width - 1)) - 1);
    localparam logic signed [width-1:0] W_MIN = -W_MAX - width'(1);

    localparam logic signed [hw-1:0] HS_ONE  = hw'(1 << frac_bits);
    localparam logic signed [hw-1:0] HS_HALF = hw'(1 << (frac_bits - 1));
    localparam logic signed [hw-1:0] HS_TWO  = hw'(2 << frac_bits);
    localparam logic [width-1:0] ONE_W     = width'(1 << frac_bits);
    localparam logic [width-1:0] QUARTER_W = width'(1 << (frac_bits - 2));

    if (width != 1 + int_bits + frac_bits) begin : g_bad_format
        $error("width must equal 1 + int_bits + frac_bits");
    end

    logic                        in_ready_d;
    logic [bw-1:0]               beat_cnt_q, beat_cnt_d;
    logic signed [width_acc-1:0] acc_q, acc_d;
    logic                        mode_q, mode_d;
    logic                        out_valid_q, out_valid_d;
    logic [width-1:0]            act_out_q, act_out_d;
    logic [width-1:0]            adot_out_d, adot_out_q;

    logic signed [pw-1:0]        act_ext [z];
    logic signed [pw-1:0]        wt_ext [z];
    logic signed [pw-1:0]        full_prod [z];
    logic signed [pw-1:0]        shifted [z];
    logic signed [width-1:0]     prod [z];
    logic signed [width_acc-1:0] beat_sum;

    // Per-lane product: unsigned activation times signed weight, rescaled and clipped to data width.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < z; i++) begin
            act_ext[i]   = signed'(pw'({1'b0, act_in_package[i*width +: width]}));
            wt_ext[i]    = pw'(signed'(wt_package[i*width +: width]));
            full_prod[i] = act_ext[i] * wt_ext[i];
            shifted[i]   = full_prod[i] >>> frac_bits;
`ifdef FF_ROUND_EN
            shifted[i]   = shifted[i] + signed'({{(pw-1){1'b0}}, full_prod[i][frac_bits-1]});
`endif
            if (shifted[i] > P_MAX) begin
                prod[i] = W_MAX;
            end else if (shifted[i] < P_MIN) begin
                prod[i] = W_MIN;
            end else begin
                prod[i] = shifted[i][width-1:0];
            end
            beat_sum = beat_sum + width_acc'(prod[i]);
        end
    end

    logic                        first_beat;
    logic                        last_beat;
    logic                        accept;
    logic                        mode_eff;
    logic signed [width_acc-1:0] acc_base;
    logic signed [width_acc-1:0] acc_sum;
    logic signed [width-1:0]     s_val;

    // Beat 0 starts from the bias instead of the stale accumulator, so cpn=1 needs no special case.
    always_comb begin
        first_beat = (beat_cnt_q == '0);
        last_beat  = (beat_cnt_q == LAST_BEAT);
        in_ready_d = ~out_valid_q | out_ready | ~last_beat;
        accept     = in_valid & in_ready_d;
        mode_eff   = first_beat ? act_mode : mode_q;
        acc_base   = first_beat ? width_acc'(signed'(bias)) : acc_q;
        acc_sum    = acc_base + beat_sum;
        if (acc_sum > A_MAX) begin
            s_val = W_MAX;
        end else if (acc_sum < A_MIN) begin
            s_val = W_MIN;
        end else begin
            s_val = acc_sum[width-1:0];
        end
    end

    logic signed [hw-1:0] s_hw;
    logic signed [hw-1:0] hs_val;
    logic [width-1:0]     act_new;
    logic [width-1:0]     adot_new;

    always_comb begin
        s_hw   = hw'(s_val);
        hs_val = s_hw >>> 2;
`ifdef FF_ROUND_EN
        hs_val = hs_val + signed'({{(hw-1){1'b0}}, s_val[1]});
`endif
        hs_val = hs_val + HS_HALF;
        if (mode_eff) begin
            if (hs_val < 0) begin
                act_new = '0;
            end else if (hs_val > HS_ONE) begin
                act_new = ONE_W;
            end else begin
                act_new = hs_val[width-1:0];
            end
            adot_new = ((s_hw > -HS_TWO) && (s_hw < HS_TWO)) ? QUARTER_W : '0;
        end else begin
            act_new  = (s_val > 0) ? s_val : '0;
            adot_new = (s_val > 0) ? ONE_W : '0;
        end
    end

    // Beat counter/accumulator advance only on accepted beats; the output slot is a single entry.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        act_out_d   = act_out_q;
        adot_out_d  = adot_out_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (first_beat) begin
                mode_d = act_mode;
            end
            if (last_beat) begin
                beat_cnt_d  = '0;
                acc_d       = '0;
                out_valid_d = 1'b1;
                act_out_d   = act_new;
                adot_out_d  = adot_new;
            end else begin
                beat_cnt_d = beat_cnt_q + bw'(1);
                acc_d      = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            act_out_q   <= '0;
            adot_out_q  <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            act_out_q   <= act_out_d;
            adot_out_q  <= adot_out_d;
        end
    end

    assign in_ready  = in_ready_d;
    assign out_valid = out_valid_q;
    assign act_out   = act_out_q;
    assign adot_out  = adot_out_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_ff_accum_processor_set.sv
// Scoreboard bench for ff_accum_processor_set (z=4, cpn=2): directed neurons push expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_ff_accum_processor_set;

    localparam int Z   = 4;
    localparam int CPN = 2;
    localparam int W   = 16;

`ifdef FF_ROUND_EN
    localparam int RND_ACT  = 8;
    localparam int RND_ADOT = 1024;
`else
    localparam int RND_ACT  = 0;
    localparam int RND_ADOT = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              act_mode;
    logic              in_valid;
    logic              in_ready;
    logic [W*Z-1:0]    act_in_package;
    logic [W*Z-1:0]    wt_package;
    logic [W-1:0]      bias;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      act_out;
    logic [W-1:0]      adot_out;
    logic [1:0]        beat_cnt;

    typedef struct packed {
        logic [W-1:0] act;
        logic [W-1:0] adot;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    ff_accum_processor_set #(
        .z(Z), .cpn(CPN), .width(W), .int_bits(5), .frac_bits(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .act_mode(act_mode),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .act_in_package(act_in_package),
        .wt_package(wt_package),
        .bias(bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .act_out(act_out),
        .adot_out(adot_out),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: a result is consumed on any edge where out_valid & out_ready hold.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got act=%0d with nothing expected", act_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_act", 32'(act_out), 32'(e.act));
                checkOutput("sb_adot", 32'(adot_out), 32'(e.adot));
            end
        end
    end

    task automatic driveBeat(input int a, input int w, input int b, input logic mode);
        logic [W-1:0] a16;
        logic [W-1:0] w16;
        a16            = a[W-1:0];
        w16            = w[W-1:0];
        act_in_package = {Z{a16}};
        wt_package     = {Z{w16}};
        bias           = b[W-1:0];
        act_mode       = mode;
        in_valid       = 1'b1;
    endtask

    task automatic sendBeat();
        int cycles;
        cycles = 0;
        while (!in_ready && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // One neuron: mode and bias are deliberately garbled on non-first beats, which must be ignored.
    task automatic applyStimulus(input int a, input int w, input int b, input logic mode,
                                 input int exp_act, input int exp_adot, input int gap);
        exp_t e;
        for (int beat = 0; beat < CPN; beat++) begin
            if (beat == 0) begin
                driveBeat(a, w, b, mode);
            end else begin
                driveBeat(a, w, 32'h1234, ~mode);
            end
            if (beat == CPN - 1) begin
                e.act  = exp_act[W-1:0];
                e.adot = exp_adot[W-1:0];
                exp_q.push_back(e);
            end
            sendBeat();
            if (beat < CPN - 1 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic waitDrain();
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 50) begin
            @(posedge clk);
            cycles++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        act_mode       = 1'b0;
        act_in_package = '0;
        wt_package     = '0;
        bias           = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_act_out", 32'(act_out), 32'd0);
        checkOutput("rst_adot_out", 32'(adot_out), 32'd0);
        checkOutput("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] ReLU basic");
        applyStimulus(1024, 512, 0, 1'b0, 4096, 1024, 0);
        checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
        waitDrain();

        $display("[TB] Hard sigmoid");
        applyStimulus(1024, 512, 0, 1'b1, 1024, 0, 0);
        applyStimulus(1024, 64, 0, 1'b1, 640, 256, 2);
        applyStimulus(1024, 512, -3072, 1'b1, 768, 256, 0);
        waitDrain();

        $display("[TB] Saturation and negative sums");
        applyStimulus(31744, 31744, 32767, 1'b0, 32767, 1024, 0);
        applyStimulus(31744, 31744, 32767, 1'b1, 1024, 0, 0);
        applyStimulus(1024, -1024, 0, 1'b0, 0, 0, 0);
        applyStimulus(1024, -1024, 0, 1'b1, 0, 0, 1);
        waitDrain();

        $display("[TB] Backpressure");
        out_ready = 1'b0;
        applyStimulus(1024, 512, 0, 1'b0, 4096, 1024, 0);
        driveBeat(1024, 64, 0, 1'b1);
        sendBeat();
        checkOutput("bp_beat_cnt", 32'(beat_cnt), 32'd1);
        driveBeat(1024, 64, 32'h1234, 1'b0);
        begin
            exp_t e;
            e.act  = 16'd640;
            e.adot = 16'd256;
            exp_q.push_back(e);
        end
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_in_ready_stall", 32'(in_ready), 32'd0);
        end
        checkOutput("bp_held_act", 32'(act_out), 32'd4096);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        sendBeat();
        checkOutput("bp_second_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_second_act", 32'(act_out), 32'd640);
        waitDrain();

        $display("[TB] Reset mid-neuron");
        driveBeat(1024, 1024, 0, 1'b0);
        sendBeat();
        checkOutput("mid_beat_cnt", 32'(beat_cnt), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1024, 1024, 0, 1'b0, 8192, 1024, 0);
        waitDrain();

        $display("[TB] Product rounding");
        applyStimulus(1, 512, 0, 1'b0, RND_ACT, RND_ADOT, 0);
        waitDrain();

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("final_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
